// File: rtl/writeback_register_file_if.sv
// Write-back / register-read bus for writeback_register_file.
// Carries the MEM/WB write-back controls and data, the decode-stage read
// addresses, and the returned read data, write-back value, valid and count.
//   master : drives write-back controls/data and read addresses (pipeline side)
//   slave  : the register file
interface writeback_register_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  Regwrite_Input;
    logic                  MemtoReg_Input;
    logic [ADDR_WIDTH-1:0] WB_Rd;
    logic [DATA_WIDTH-1:0] Data_Memory_Data;
    logic [DATA_WIDTH-1:0] ALU_Data;
    logic [ADDR_WIDTH-1:0] Rs_Addr;
    logic [ADDR_WIDTH-1:0] Rt_Addr;
    logic [DATA_WIDTH-1:0] Rs_Data;
    logic [DATA_WIDTH-1:0] Rt_Data;
    logic [DATA_WIDTH-1:0] WB_Data;
    logic                  WB_Valid;
    logic [31:0]           Writeback_Count;

    modport master (
        output Regwrite_Input, MemtoReg_Input, WB_Rd, Data_Memory_Data, ALU_Data,
        output Rs_Addr, Rt_Addr,
        input  Rs_Data, Rt_Data, WB_Data, WB_Valid, Writeback_Count
    );

    modport slave (
        input  Regwrite_Input, MemtoReg_Input, WB_Rd, Data_Memory_Data, ALU_Data,
        input  Rs_Addr, Rt_Addr,
        output Rs_Data, Rt_Data, WB_Data, WB_Valid, Writeback_Count
    );
endinterface

// File: rtl/writeback_register_file.sv
// Write-back stage register file: 2**ADDR_WIDTH flop-based registers with two
// combinational read ports, same-cycle write-to-read bypass, a hard-wired zero
// register 0, and a free-running 32-bit count of committed writes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears registers and count)
//   bus   : writeback_register_file_if.slave (write-back inputs, read ports,
//           WB_Data / WB_Valid / Writeback_Count outputs)
module writeback_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic                        clk,
    input logic                        rst_n,
    writeback_register_file_if.slave   bus
);
    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];
    logic [31:0]           count_q;
    logic [31:0]           count_d;

    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_valid;
    logic                  rs_bypass;
    logic                  rt_bypass;

    // Write-back mux has no reset term; it stays live during reset.
    always_comb begin
        wb_data = bus.MemtoReg_Input ? bus.Data_Memory_Data : bus.ALU_Data;
    end

    // Including rst_n here suppresses both commits and bypass while in reset.
    always_comb begin
        wb_valid  = bus.Regwrite_Input && (bus.WB_Rd != '0) && rst_n;
        rs_bypass = wb_valid && (bus.Rs_Addr == bus.WB_Rd);
        rt_bypass = wb_valid && (bus.Rt_Addr == bus.WB_Rd);
    end

    // Register 0 is never a write target (wb_valid excludes it), so it holds
    // its reset value of zero forever.
    always_comb begin
        regs_d = regs_q;
        if (wb_valid) begin
            regs_d[bus.WB_Rd] = wb_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (wb_valid) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        if (!rst_n) begin
            bus.Rs_Data = '0;
            bus.Rt_Data = '0;
        end else begin
            bus.Rs_Data = rs_bypass ? wb_data : regs_q[bus.Rs_Addr];
            bus.Rt_Data = rt_bypass ? wb_data : regs_q[bus.Rt_Addr];
        end
    end

    always_comb begin
        bus.WB_Data         = wb_data;
        bus.WB_Valid        = wb_valid;
        bus.Writeback_Count = count_q;
    end
endmodule

// File: tb/tb_writeback_register_file.sv
// Self-checking bench for writeback_register_file: directed scenarios plus
// randomized traffic checked against an array-based reference model.
module tb_writeback_register_file;
    logic clk;
    logic rst_n;

    writeback_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    writeback_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total;
    int unsigned n_bad;

    // Reference model: architectural register contents and commit count.
    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
        mdl_cnt = 32'h0;
    endtask

    function automatic logic [31:0] exp_wb_data();
        return bus.MemtoReg_Input ? bus.Data_Memory_Data : bus.ALU_Data;
    endfunction

    function automatic logic exp_wb_valid();
        return bus.Regwrite_Input && (bus.WB_Rd != 5'd0) && rst_n;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!rst_n) return 32'h0;
        if (exp_wb_valid() && a == bus.WB_Rd) return exp_wb_data();
        return mdl_regs[a];
    endfunction

    // Apply inputs (called at negedge). Reset is asynchronous, so the model
    // clears as soon as rst_n drops.
    task automatic set_in(input logic rst, input logic rw, input logic m2r,
                          input logic [4:0] rd, input logic [31:0] mem,
                          input logic [31:0] alu, input logic [4:0] rs,
                          input logic [4:0] rt);
        rst_n                = rst;
        bus.Regwrite_Input   = rw;
        bus.MemtoReg_Input   = m2r;
        bus.WB_Rd            = rd;
        bus.Data_Memory_Data = mem;
        bus.ALU_Data         = alu;
        bus.Rs_Addr          = rs;
        bus.Rt_Addr          = rt;
        if (!rst) mdl_clear();
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wb_data"}, bus.WB_Data, exp_wb_data());
        check({tag, ".wb_valid"}, {31'h0, bus.WB_Valid}, {31'h0, exp_wb_valid()});
        check({tag, ".rs"}, bus.Rs_Data, exp_read(bus.Rs_Addr));
        check({tag, ".rt"}, bus.Rt_Data, exp_read(bus.Rt_Addr));
        check({tag, ".count"}, bus.Writeback_Count, mdl_cnt);
    endtask

    // Advance one clock, committing the pending write into the model.
    task automatic cycle();
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
        v  = exp_wb_valid();
        rd = bus.WB_Rd;
        d  = exp_wb_data();
        @(posedge clk);
        if (v) begin
            mdl_regs[rd] = d;
            mdl_cnt      = mdl_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        mdl_clear();

        // Reset state: writes requested during reset are ignored.
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b1, 5'd5, 32'h1111_2222, 32'h3333_4444, 5'd5, 5'd0);
        cycle();
        #1;
        check("rst.rs", bus.Rs_Data, 32'h0);
        check("rst.valid", {31'h0, bus.WB_Valid}, 32'h0);
        check("rst.count", bus.Writeback_Count, 32'h0);
        check("rst.wbdata", bus.WB_Data, 32'h1111_2222);

        // Write then read r8.
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, 5'd8, 32'h0, 32'h1234_5678, 5'd0, 5'd0);
        check_all("wr8");
        cycle();
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd0);
        check("wr8.rs", bus.Rs_Data, 32'h1234_5678);
        check("wr8.count", bus.Writeback_Count, 32'd1);

        // Bypass on both ports in the same cycle.
        set_in(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h0, 5'd3, 5'd3);
        check("byp.rs", bus.Rs_Data, 32'hDEAD_BEEF);
        check("byp.rt", bus.Rt_Data, 32'hDEAD_BEEF);
        check("byp.valid", {31'h0, bus.WB_Valid}, 32'd1);
        cycle();

        // Register 0 protection.
        set_in(1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check("r0.valid", {31'h0, bus.WB_Valid}, 32'h0);
        check("r0.rs_pre", bus.Rs_Data, 32'h0);
        cycle();
        #1;
        check("r0.rs", bus.Rs_Data, 32'h0);
        check("r0.count", bus.Writeback_Count, 32'd2);

        // Write disabled: r9 keeps its prior value, no bypass.
        set_in(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0BAD_F00D, 5'd0, 5'd0);
        cycle();
        set_in(1'b1, 1'b0, 1'b0, 5'd9, 32'h0, 32'hAAAA_5555, 5'd9, 5'd9);
        check("dis.rs_pre", bus.Rs_Data, 32'h0BAD_F00D);
        check("dis.wbdata", bus.WB_Data, 32'hAAAA_5555);
        cycle();
        #1;
        check("dis.rs", bus.Rs_Data, 32'h0BAD_F00D);
        check("dis.count", bus.Writeback_Count, 32'd3);

        // Randomized traffic with occasional reset pulses; addresses biased to
        // a small range so bypass hits are frequent.
        @(negedge clk);
        for (int i = 0; i < 500; i++) begin
            logic [4:0] rd, rs, rt;
            rd = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rs = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7));
            rt = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
            set_in(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                   1'($urandom), rd, $urandom, $urandom, rs, rt);
            check_all("rnd");
            cycle();
        end

        // Mid-run reset clears r5 immediately and discards coincident writes.
        set_in(1'b1, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0000_0055, 5'd5, 5'd0);
        cycle();
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        check("mid.r5_pre", bus.Rs_Data, 32'h0000_0055);
        @(posedge clk);
        #2;
        set_in(1'b0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0000_0066, 5'd5, 5'd5);
        check("mid.rs", bus.Rs_Data, 32'h0);
        check("mid.count", bus.Writeback_Count, 32'h0);
        @(negedge clk);
        cycle();
        #1;
        check("mid.rs_hold", bus.Rs_Data, 32'h0);
        check("mid.cnt_hold", bus.Writeback_Count, 32'h0);

        // First write lands on the first edge after reset release.
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0000_0077, 5'd0, 5'd0);
        cycle();
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        check("rel.rs", bus.Rs_Data, 32'h0000_0077);
        check("rel.count", bus.Writeback_Count, 32'd1);

        // Counter wrap.
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        mdl_cnt = 32'hFFFF_FFFF;
        set_in(1'b1, 1'b1, 1'b0, 5'd1, 32'h0, 32'hCAFE_0001, 5'd0, 5'd0);
        check("wrap.pre", bus.Writeback_Count, 32'hFFFF_FFFF);
        cycle();
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd0);
        check("wrap.count", bus.Writeback_Count, 32'h0);
        check("wrap.r1", bus.Rs_Data, 32'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
